// File: rtl/i2c_pkg.sv
// Shared types and widths for the I2C bus scheduler.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_AACK,
    ST_DATA,
    ST_DACK,
    ST_STOP
  } i2c_state_t;

endpackage

// File: rtl/i2c_bus_sched_if.sv
// Requester and I2C line bundle between the scheduler and its environment.
interface i2c_bus_sched_if #(
  parameter int NREQ = 4
);

  logic [NREQ-1:0]                         req;
  logic [NREQ*i2c_pkg::I2C_ADDR_W-1:0]     addr;
  logic [NREQ-1:0]                         rw;
  logic [NREQ*i2c_pkg::I2C_BYTE_W-1:0]     wdata;
  logic [NREQ-1:0]                         grant;
  logic [NREQ-1:0]                         done;
  logic [i2c_pkg::I2C_BYTE_W-1:0]          rdata;
  logic                                    ack_err;
  logic                                    data_clk;
  logic                                    scl_ena;
  logic                                    sda_oe;
  logic                                    sda_in;

  modport master (
    input  req, addr, rw, wdata, data_clk, sda_in,
    output grant, done, rdata, ack_err, scl_ena, sda_oe
  );

  modport slave (
    output req, addr, rw, wdata, data_clk, sda_in,
    input  grant, done, rdata, ack_err, scl_ena, sda_oe
  );

endinterface

// File: rtl/i2c_rr_arbiter.sv
// Rotate-priority pick: first set request strictly after the last winner.
module i2c_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [IDX_W-1:0] idx_o
);

  int               cand;
  logic [IDX_W-1:0] cidx;
  logic             found;

  // Explicit wrap keeps the rotation correct for non-power-of-two NREQ.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    cand  = 0;
    cidx  = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = int'(last_i) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      cidx = IDX_W'(cand);
      if (!found && req_i[cidx]) begin
        found       = 1'b1;
        gnt_o[cidx] = 1'b1;
        idx_o       = cidx;
      end
    end
  end

endmodule

// File: rtl/i2c_bus_sched.sv
// Round-robin owner of the shared I2C clock generator; sequences one
// single-byte transaction per grant on data_clk rising-edge ticks.
module i2c_bus_sched
  import i2c_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input logic             clk,
  input logic             rst_n,
  i2c_bus_sched_if.master bus
);

  logic                  dclk_q;
  logic                  tick;
  i2c_state_t            state_q;
  logic [IDX_W-1:0]      last_q, gidx_q;
  logic [NREQ-1:0]       grant_q, done_q;
  logic [I2C_BYTE_W-1:0] sh_q, wdata_q, rdata_q;
  logic [2:0]            cnt_q;
  logic                  rw_q, err_q, ack_err_q, scl_ena_q, sda_oe_q;

  logic [NREQ-1:0]       arb_gnt;
  logic [IDX_W-1:0]      arb_idx;
  logic [I2C_ADDR_W-1:0] addr_sel;
  logic                  rw_sel;
  logic [I2C_BYTE_W-1:0] wdata_sel;

  assign tick = bus.data_clk & ~dclk_q;

  i2c_rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
    .req_i  (bus.req),
    .last_i (last_q),
    .gnt_o  (arb_gnt),
    .idx_o  (arb_idx)
  );

  always_comb begin
    addr_sel  = '0;
    rw_sel    = 1'b0;
    wdata_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) begin
        addr_sel  = bus.addr[i*I2C_ADDR_W +: I2C_ADDR_W];
        rw_sel    = bus.rw[i];
        wdata_sel = bus.wdata[i*I2C_BYTE_W +: I2C_BYTE_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dclk_q    <= 1'b0;
      state_q   <= ST_IDLE;
      last_q    <= IDX_W'(NREQ - 1);
      gidx_q    <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      sh_q      <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      cnt_q     <= '0;
      rw_q      <= 1'b0;
      err_q     <= 1'b0;
      ack_err_q <= 1'b0;
      scl_ena_q <= 1'b0;
      sda_oe_q  <= 1'b0;
    end else begin
      dclk_q <= bus.data_clk;
      done_q <= '0;
      case (state_q)
        ST_IDLE: begin
          // Arbitration runs every clock; only the START step waits for a tick.
          if (grant_q == '0) begin
            if (|bus.req) begin
              grant_q <= arb_gnt;
              gidx_q  <= arb_idx;
              sh_q    <= {addr_sel, rw_sel};
              wdata_q <= wdata_sel;
              rw_q    <= rw_sel;
              err_q   <= 1'b0;
            end
          end else if (tick) begin
            state_q   <= ST_START;
            sda_oe_q  <= 1'b1;
            scl_ena_q <= 1'b1;
          end
        end
        ST_START: if (tick) begin
          state_q  <= ST_ADDR;
          sda_oe_q <= ~sh_q[7];
          sh_q     <= {sh_q[6:0], 1'b0};
        end
        ST_ADDR: if (tick) begin
          cnt_q <= cnt_q + 3'd1;
          sh_q  <= {sh_q[6:0], 1'b0};
          if (cnt_q == 3'd7) begin
            state_q  <= ST_AACK;
            sda_oe_q <= 1'b0;
          end else begin
            sda_oe_q <= ~sh_q[7];
          end
        end
        ST_AACK: if (tick) begin
          if (bus.sda_in) begin
            err_q    <= 1'b1;
            state_q  <= ST_STOP;
            sda_oe_q <= 1'b1;
          end else begin
            state_q  <= ST_DATA;
            sda_oe_q <= rw_q ? 1'b0 : ~wdata_q[7];
            sh_q     <= {wdata_q[6:0], 1'b0};
          end
        end
        ST_DATA: if (tick) begin
          cnt_q <= cnt_q + 3'd1;
          sh_q  <= {sh_q[6:0], rw_q & bus.sda_in};
          if (cnt_q == 3'd7) begin
            state_q  <= ST_DACK;
            sda_oe_q <= 1'b0;
          end else if (!rw_q) begin
            sda_oe_q <= ~sh_q[7];
          end
        end
        ST_DACK: if (tick) begin
          if (!rw_q && bus.sda_in) err_q <= 1'b1;
          state_q  <= ST_STOP;
          sda_oe_q <= 1'b1;
        end
        ST_STOP: if (tick) begin
          state_q   <= ST_IDLE;
          sda_oe_q  <= 1'b0;
          scl_ena_q <= 1'b0;
          done_q    <= grant_q;
          grant_q   <= '0;
          last_q    <= gidx_q;
          rdata_q   <= sh_q;
          ack_err_q <= err_q;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.grant   = grant_q;
  assign bus.done    = done_q;
  assign bus.rdata   = rdata_q;
  assign bus.ack_err = ack_err_q;
  assign bus.scl_ena = scl_ena_q;
  assign bus.sda_oe  = sda_oe_q;

endmodule
